// File: rtl/sad_search_if.sv
// sad_search_if: row-fetch, SAD datapath and result signals of sad_search_ctrl.
// SAD_EARLY_TERM_EN adds early_thresh_i / early_term_o.
interface sad_search_if #(
    parameter int ROW_W = 6,
    parameter int ACC_W = 15
);
    logic             start_i;
    logic             busy_o;
    logic             row_req_o;
    logic [ROW_W-1:0] row_idx_o;
    logic             row_valid_i;
    logic [63:0]      row_filter_i;
    logic [63:0]      row_ref_i;
    logic [63:0]      sad_filter_pix_o;
    logic [63:0]      sad_ref_pix_o;
    logic             sad_input_ready_o;
    logic [59:0]      sad_in_i;
    logic             done_o;
    logic [2:0]       best_idx_o;
    logic [ACC_W-1:0] best_sad_o;
`ifdef SAD_EARLY_TERM_EN
    logic [ACC_W-1:0] early_thresh_i;
    logic             early_term_o;
`endif
    modport master (
`ifdef SAD_EARLY_TERM_EN
        input early_thresh_i, output early_term_o,
`endif
        input start_i, row_valid_i, row_filter_i, row_ref_i, sad_in_i,
        output busy_o, row_req_o, row_idx_o, sad_filter_pix_o, sad_ref_pix_o,
        output sad_input_ready_o, done_o, best_idx_o, best_sad_o
    );
    modport slave (
`ifdef SAD_EARLY_TERM_EN
        output early_thresh_i, input early_term_o,
`endif
        output start_i, row_valid_i, row_filter_i, row_ref_i, sad_in_i,
        input busy_o, row_req_o, row_idx_o, sad_filter_pix_o, sad_ref_pix_o,
        input sad_input_ready_o, done_o, best_idx_o, best_sad_o
    );
endinterface

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: sequences a sub-pel SAD search over ROWS rows and picks the best of five candidates.
// Optional SAD_EARLY_TERM_EN: abort once every accumulator exceeds early_thresh.
module sad_search_ctrl #(
    parameter int ROWS  = 8,
    parameter int ROW_W = 6,
    parameter int ACC_W = 15
) (
    input logic clk,
    input logic rst,
    sad_search_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, ACCUM, COMPARE, DONE} state_t;
    state_t           state_q;
    logic [ACC_W-1:0] acc_q [5];
    logic [ACC_W-1:0] acc_d [5];
    logic [ROW_W-1:0] row_cnt_q;
    logic [2:0]       cmp_q, cand_idx_q, best_idx_q, cand_k;
    logic [ACC_W-1:0] cand_sad_q, best_sad_q, cand_v;
    logic             busy_q, row_req_q, ready_q, done_q, take, last_row, stop;
    logic [63:0]      filt_q, ref_q;
`ifdef SAD_EARLY_TERM_EN
    logic [ACC_W-1:0] thresh_q;
    logic             hit_q, early_term_q, over;
`endif
    always_comb begin
        for (int k = 0; k < 5; k++) acc_d[k] = acc_q[k] + ACC_W'(bus.sad_in_i[12*k +: 12]);
        // Scan order F, RH, LH, RQ, LQ; strict less keeps ties with the earlier entry
        cand_k   = cmp_q == 3'd0 ? 3'd2 : cmp_q == 3'd1 ? 3'd1 : cmp_q == 3'd2 ? 3'd3 :
                   cmp_q == 3'd3 ? 3'd0 : 3'd4;
        cand_v   = acc_q[cand_k];
        take     = cmp_q == 3'd0 || cand_v < cand_sad_q;
        last_row = row_cnt_q == ROW_W'(ROWS - 1);
`ifdef SAD_EARLY_TERM_EN
        over = 1'b1;
        for (int k = 0; k < 5; k++) over = over & (acc_d[k] > thresh_q);
        stop = last_row || over;
`else
        stop = last_row;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '{default: '0};
            row_cnt_q  <= '0;
            cmp_q      <= '0;
            cand_idx_q <= '0;
            cand_sad_q <= '0;
            best_idx_q <= '0;
            best_sad_q <= '0;
            busy_q     <= 1'b0;
            row_req_q  <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            filt_q     <= '0;
            ref_q      <= '0;
`ifdef SAD_EARLY_TERM_EN
            thresh_q     <= '0;
            hit_q        <= 1'b0;
            early_term_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.start_i) begin
                    state_q   <= FETCH;
                    acc_q     <= '{default: '0};
                    row_cnt_q <= '0;
                    busy_q    <= 1'b1;
                    row_req_q <= 1'b1;
`ifdef SAD_EARLY_TERM_EN
                    thresh_q     <= bus.early_thresh_i;
                    hit_q        <= 1'b0;
                    early_term_q <= 1'b0;
`endif
                end
                FETCH: if (bus.row_valid_i) begin
                    state_q   <= ACCUM;
                    filt_q    <= bus.row_filter_i;
                    ref_q     <= bus.row_ref_i;
                    row_req_q <= 1'b0;
                    ready_q   <= 1'b1;
                end
                ACCUM: begin
                    acc_q     <= acc_d;
                    row_cnt_q <= row_cnt_q + 1'b1;
                    ready_q   <= 1'b0;
                    state_q   <= stop ? COMPARE : FETCH;
                    row_req_q <= !stop;
                    cmp_q     <= '0;
`ifdef SAD_EARLY_TERM_EN
                    hit_q <= stop && !last_row;
`endif
                end
                COMPARE: begin
                    cand_idx_q <= take ? cand_k : cand_idx_q;
                    cand_sad_q <= take ? cand_v : cand_sad_q;
                    cmp_q      <= cmp_q + 1'b1;
                    if (cmp_q == 3'd4) begin
                        best_idx_q <= take ? cand_k : cand_idx_q;
                        best_sad_q <= take ? cand_v : cand_sad_q;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
`ifdef SAD_EARLY_TERM_EN
                        early_term_q <= hit_q;
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.busy_o            = busy_q;
    assign bus.row_req_o         = row_req_q;
    assign bus.row_idx_o         = row_cnt_q;
    assign bus.sad_filter_pix_o  = filt_q;
    assign bus.sad_ref_pix_o     = ref_q;
    assign bus.sad_input_ready_o = ready_q;
    assign bus.done_o            = done_q;
    assign bus.best_idx_o        = best_idx_q;
    assign bus.best_sad_o        = best_sad_q;
`ifdef SAD_EARLY_TERM_EN
    assign bus.early_term_o      = early_term_q;
`endif
endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb_sad_search_ctrl: randomized searches against a sum-and-pick reference model, scoreboarded on done.
module tb_sad_search_ctrl;
    localparam int ROWS = 8, ROW_W = 6, ACC_W = 15;
    typedef struct {logic [2:0] idx; logic [ACC_W-1:0] sad; int cyc;} exp_t;
    logic clk = 0, rst = 1;
    int cyc = 0, checks = 0, errors = 0, nacc = 0;
    exp_t q[$];
    logic [11:0] sads [ROWS][5];
    sad_search_if #(.ROW_W(ROW_W), .ACC_W(ACC_W)) ifc();
    sad_search_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W), .ACC_W(ACC_W)) dut(.clk(clk), .rst(rst), .bus(ifc.master));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Stand-in datapath: the bench encodes the wanted SADs as filter XOR ref
    assign ifc.sad_in_i = ifc.sad_filter_pix_o[59:0] ^ ifc.sad_ref_pix_o[59:0];
`ifdef SAD_EARLY_TERM_EN
    assign ifc.early_thresh_i = '1;
`endif
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic exp_t model();
        int s[5];
        int ord[5] = '{2, 1, 3, 0, 4};
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            s[k] = 0;
            for (int r = 0; r < ROWS; r++) s[k] += int'(sads[r][k]);
        end
        e.idx = 3'(ord[0]);
        for (int j = 1; j < 5; j++) if (s[ord[j]] < s[e.idx]) e.idx = 3'(ord[j]);
        e.sad = ACC_W'(s[e.idx]);
        e.cyc = 0;
        return e;
    endfunction
    task automatic fill(input int a0, input int a1, input int a2, input int a3, input int a4);
        for (int r = 0; r < ROWS; r++) begin
            sads[r][0] = 12'(a0); sads[r][1] = 12'(a1); sads[r][2] = 12'(a2);
            sads[r][3] = 12'(a3); sads[r][4] = 12'(a4);
        end
    endtask
    always @(negedge clk) begin
        if (!ifc.busy_o) nacc = 0;
        else if (ifc.sad_input_ready_o) nacc++;
        if (ifc.done_o) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("best_idx", ifc.best_idx_o, e.idx);
                chk("best_sad", ifc.best_sad_o, e.sad);
                chk("done_cycle", cyc, e.cyc);
                chk("rows_accumulated", nacc, ROWS);
            end
        end
    end
    task automatic run_search(input int dmin, input int dmax, input bit noise, input int abort_row);
        int d[ROWS];
        int dsum = 0, t;
        exp_t e;
        logic [59:0] v;
        logic [63:0] r;
        for (int k = 0; k < ROWS; k++) begin
            d[k] = $urandom_range(dmax, dmin);
            dsum += d[k];
        end
        @(negedge clk);
        ifc.start_i = 1;
        e = model();
        e.cyc = cyc + 6 + 2 * ROWS + dsum;
        if (abort_row >= ROWS) q.push_back(e);
        @(negedge clk);
        ifc.start_i = 0;
        chk("busy_rise", ifc.busy_o, 1);
        for (int k = 0; k < ROWS; k++) begin
            t = 0;
            while (!ifc.row_req_o) begin
                ifc.row_valid_i = noise & 1'($urandom_range(1, 0));
                ifc.start_i = noise & 1'($urandom_range(1, 0));
                ifc.row_filter_i = {$urandom, $urandom};
                ifc.row_ref_i = {$urandom, $urandom};
                @(negedge clk);
                if (++t > 20) begin
                    chk("row_req_timeout", 0, 1);
                    ifc.row_valid_i = 0; ifc.start_i = 0;
                    return;
                end
            end
            ifc.row_valid_i = 0;
            ifc.start_i = 0;
            if (k == abort_row) begin
                rst = 1;
                @(negedge clk);
                rst = 0;
                chk("abort_busy", ifc.busy_o, 0);
                chk("abort_row_req", ifc.row_req_o, 0);
                repeat (4) @(negedge clk);
                return;
            end
            repeat (d[k]) begin
                chk("row_req_held", ifc.row_req_o, 1);
                @(negedge clk);
            end
            chk("row_idx", ifc.row_idx_o, k);
            for (int j = 0; j < 5; j++) v[12*j +: 12] = sads[k][j];
            r = {$urandom, $urandom};
            ifc.row_ref_i = r;
            ifc.row_filter_i = {4'($urandom), v ^ r[59:0]};
            ifc.row_valid_i = 1;
            @(negedge clk);
            ifc.row_valid_i = 0;
        end
        t = 0;
        while (!ifc.done_o) begin
            @(negedge clk);
            if (++t > 20) begin
                chk("done_timeout", 0, 1);
                return;
            end
        end
        @(negedge clk);
        chk("busy_fall", ifc.busy_o, 0);
        chk("done_pulse", ifc.done_o, 0);
        repeat (2) begin
            ifc.row_valid_i = noise;
            @(negedge clk);
        end
        ifc.row_valid_i = 0;
        chk("best_idx_hold", ifc.best_idx_o, e.idx);
        chk("best_sad_hold", ifc.best_sad_o, e.sad);
    endtask
    initial begin
        ifc.start_i = 0; ifc.row_valid_i = 0; ifc.row_filter_i = '0; ifc.row_ref_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", ifc.busy_o, 0);
        chk("rst_row_req", ifc.row_req_o, 0);
        chk("rst_row_idx", ifc.row_idx_o, 0);
        chk("rst_filter_pix", ifc.sad_filter_pix_o, 0);
        chk("rst_ref_pix", ifc.sad_ref_pix_o, 0);
        chk("rst_ready", ifc.sad_input_ready_o, 0);
        chk("rst_done", ifc.done_o, 0);
        chk("rst_best_idx", ifc.best_idx_o, 0);
        chk("rst_best_sad", ifc.best_sad_o, 0);
        rst = 0;
        fill(7, 3, 100, 9, 5);
        run_search(0, 0, 0, ROWS);
        fill(10, 10, 10, 10, 10);
        run_search(0, 0, 0, ROWS);
        fill(9, 4, 60, 4, 50);
        run_search(0, 0, 0, ROWS);
        fill(7, 3, 100, 9, 5);
        run_search(3, 3, 0, ROWS);
        run_search(0, 0, 0, 3);
        run_search(0, 0, 0, ROWS);
        run_search(0, 2, 1, ROWS);
        for (int n = 0; n < 20; n++) begin
            bit tie = 1'($urandom_range(1, 0));
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < 5; k++)
                    sads[r][k] = tie ? 12'($urandom_range(3, 0)) : 12'($urandom_range(4095, 0));
            run_search(0, 3, 1'($urandom_range(1, 0)), ROWS);
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/sad_search_ctrl.md
Name: sad_search_ctrl

Overview:
Sequences one horizontal sub-pel search over a block of ROWS pixel rows using the combinational SAD datapath. It fetches a filter row and a reference row per step, presents them to the SAD datapath, and accumulates the five per-row SADs (RQ, RH, F, LH, LQ). It then selects the best candidate and reports its index and accumulated SAD. It sits between the row buffer/memory and the SAD datapath, under the motion-estimation top.

Parameters:
ROWS, 8, rows per block (2..64)
ROW_W, 6, width of row_idx; must satisfy 2^ROW_W >= ROWS
ACC_W, 15, accumulator width; 12 + ceil(log2(ROWS)), never overflows

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to begin a search; honoured only in IDLE
busy  out  1  high in every state except IDLE
row_req  out  1  row fetch request; held until accepted
row_idx  out  ROW_W  row being requested (0..ROWS-1)
row_valid  in  1  row data valid; accepted only when row_req=1
row_filter  in  64  8 filter pixels, byte 0 = pixel 0
row_ref  in  64  8 reference pixels, byte 0 = pixel 0
sad_filter_pix  out  64  registered filter row to SAD datapath
sad_ref_pix  out  64  registered reference row to SAD datapath
sad_input_ready  out  1  high while SAD datapath inputs are valid
sad_in  in  60  five 12-bit SADs: [11:0]=0 RQ, [23:12]=1 RH, [35:24]=2 F, [47:36]=3 LH, [59:48]=4 LQ
done  out  1  one-cycle pulse; best_idx/best_sad valid
best_idx  out  3  winning candidate 0..4
best_sad  out  ACC_W  accumulated SAD of winner

Behaviour:
- Reset: state=IDLE; all outputs 0, including busy, row_req, row_idx, sad_*_pix, sad_input_ready, done, best_idx and best_sad. Accumulators and row counter are cleared. Reset mid-search aborts immediately; no done pulse is issued.
- States: IDLE, FETCH, ACCUM, COMPARE, DONE.
- IDLE: start=1 clears the five accumulators and row_cnt, then goes to FETCH. start in any other state is ignored and not queued.
- FETCH: row_req=1, row_idx=row_cnt. When row_valid=1, the block latches row_filter into sad_filter_pix and row_ref into sad_ref_pix, then goes to ACCUM. Any number of wait cycles is allowed. row_valid while row_req=0 is ignored. Only one row is ever in flight.
- ACCUM (1 cycle): sad_input_ready=1 and row_req=0. Each acc[k] += zero-extended sad_in slice k. row_cnt increments. If row_cnt was ROWS-1, go to COMPARE; otherwise go to FETCH.
- sad_*_pix hold their last value outside FETCH accept cycles. The SAD datapath is combinational, so sad_in is sampled in the same ACCUM cycle.
- COMPARE (5 cycles): sequential scan in preference order 2, 1, 3, 0, 4 (F, RH, LH, RQ, LQ). The first candidate loads as best. A later candidate replaces best only if strictly less, so ties go to the earlier entry in that order.
- DONE (1 cycle): done=1, then return to IDLE. best_idx/best_sad are registered at the end of COMPARE and hold until the next DONE or reset.
- Timing with row_valid tied high and start in cycle 0: row k accepted in cycle 1+2k, COMPARE in cycles 1+2·ROWS..5+2·ROWS, done in cycle 6+2·ROWS (cycle 22 for ROWS=8).
- busy rises the cycle after start and falls the cycle after done.

Optional Feature:
SAD_EARLY_TERM_EN
- Defined: adds input early_thresh [ACC_W-1:0] (sampled at start) and output early_term [1].
  - In ACCUM, if every updated accumulator is > early_thresh, remaining rows are skipped and the state goes straight to COMPARE.
  - early_term=1 alongside done; it is cleared on the next start or on reset.
  - best_sad reports the partial sum.
- Undefined: neither port exists, and all ROWS rows are always processed.

Test Plan:
- Reset during FETCH of row 3 → next cycle busy=0, row_req=0; no done pulse; a new start runs the full 8 rows.
- ROWS=8, row_valid tied 1, sad_in slices {idx4..0}={5,9,100,3,7} every row → done at cycle 22, best_idx=1, best_sad=24.
- All slices = 10 → tie across all five → best_idx=2, best_sad=80. Slices {4:50, 3:4, 2:60, 1:4, 0:9} → best_idx=1, best_sad=32.
- row_valid delayed 3 cycles on each row → row_idx steps 0..7, row_req held throughout each wait, done at cycle 46, result unchanged.
- start pulsed while busy, and row_valid pulsed in ACCUM/IDLE → both ignored; exactly 8 accumulations and one done pulse.
- SAD_EARLY_TERM_EN defined, early_thresh=50, all slices=30 → abort after row 1 (acc=60), early_term=1, best_idx=2, best_sad=60, done at cycle 10.
